// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types used by the cache hierarchy.
// Line tags drop the in-line byte offset so that lines can be matched by address.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;
    typedef logic [11:0]  lc3b_line_tag;

    localparam int LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP    = 2'd1,
        MEMREAD = 2'd2,
        DRAIN   = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_fifo_array.sv
// Circular store of buffered dirty lines with a parallel tag search.
// Coalescing keeps at most one entry per line, so the first hit found is the only one.
module wb_fifo_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  lc3b_line_tag lookup_tag,
    output logic         hit,
    output logic [PW-1:0] hit_idx,
    output lc3b_burst    hit_data,
    input  logic         push,
    input  logic         coal,
    input  lc3b_line_tag wr_tag,
    input  lc3b_burst    wr_data,
    input  logic         pop,
    output lc3b_line_tag head_tag,
    output lc3b_burst    head_data,
    output logic         full,
    output logic         empty
);

    lc3b_line_tag  tag_q  [DEPTH];
    lc3b_burst     data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          empty_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign hit_data  = data_q[hit_idx];
    assign head_tag  = tag_q[head_q];
    assign head_data = data_q[head_q];
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = empty_q;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // Payload storage carries no reset; valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= wr_tag;
            data_q[tail_q] <= wr_data;
        end else if (coal) begin
            data_q[hit_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/l2_write_buffer.sv
// Eviction buffer between L2 and physical memory: absorbs writebacks,
// forwards buffered lines to read misses and drains oldest-first when idle or full.
//
// state   | meaning
// IDLE    | arbitrate L2 request or start an idle drain
// RESP    | one-cycle mem_resp to L2
// MEMREAD | read miss outstanding on pmem
// DRAIN   | head entry being written to pmem
module l2_write_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    wb_state_e     state;
    lc3b_line_tag  req_tag;
    logic          hit;
    logic [PW-1:0] hit_idx;
    lc3b_burst     hit_data;
    lc3b_line_tag  head_tag;
    lc3b_burst     head_data;
    logic          full;
    logic          push;
    logic          coal;
    logic          pop;
    logic [LINE_OFFSET_BITS-1:0] unused_addr_bits;

    assign req_tag          = mem_address[15:LINE_OFFSET_BITS];
    assign unused_addr_bits = mem_address[LINE_OFFSET_BITS-1:0];

    // Reads take precedence, so a write is only absorbed when no read is pending.
    assign push = (state == IDLE) && !mem_read && mem_write && !hit && !full;
    assign coal = (state == IDLE) && !mem_read && mem_write && hit;
    assign pop  = (state == DRAIN) && pmem_resp;

    wb_fifo_array #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (req_tag),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_data   (hit_data),
        .push       (push),
        .coal       (coal),
        .wr_tag     (req_tag),
        .wr_data    (mem_wdata),
        .pop        (pop),
        .head_tag   (head_tag),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read) begin
                        if (hit) begin
                            mem_rdata <= hit_data;
                            mem_resp  <= 1'b1;
                            state     <= RESP;
                        end else begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, {LINE_OFFSET_BITS{1'b0}}};
                            state        <= MEMREAD;
                        end
                    end else if (mem_write && (hit || !full)) begin
                        mem_resp <= 1'b1;
                        state    <= RESP;
                    end else if (mem_write || !empty) begin
                        // Full-buffer write: make room first, the write retries afterwards.
                        pmem_write   <= 1'b1;
                        pmem_address <= {head_tag, {LINE_OFFSET_BITS{1'b0}}};
                        pmem_wdata   <= head_data;
                        state        <= DRAIN;
                    end
                end
                RESP: begin
                    mem_resp <= 1'b0;
                    state    <= IDLE;
                end
                MEMREAD: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        mem_rdata <= pmem_rdata;
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed self-checking bench for l2_write_buffer with hand-computed expectations.
module tb_l2_write_buffer;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         empty;

    int n_chk;
    int n_fail;

    localparam logic [127:0] DAT_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DAT_B = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DAT_C = 128'hCCCC_CCCC_0000_0000_CCCC_CCCC_0000_0001;
    localparam logic [127:0] DAT_D = 128'hDDDD_0000_DDDD_0000_DDDD_0000_DDDD_0002;
    localparam logic [127:0] DAT_E = 128'hEEEE_EEEE_EEEE_EEEE_0000_0000_0000_0040;
    localparam logic [127:0] DAT_G = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
    localparam logic [127:0] DAT_R = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    l2_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a drain, verify its line, then complete it after one cycle of latency.
    task automatic drain(input string tag, input logic [15:0] exp_addr, input logic [127:0] exp_data);
        int n;
        n = 0;
        while (!pmem_write && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"},  pmem_write,   1);
        chk({tag, "_rd0"},  pmem_read,    0);
        chk({tag, "_addr"}, pmem_address, exp_addr);
        chk({tag, "_data"}, pmem_wdata,   exp_data);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
    endtask

    initial begin
        int n;
        logic flag;
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        tick();
        tick();

        chk("rst_mem_resp",   mem_resp,     0);
        chk("rst_pmem_read",  pmem_read,    0);
        chk("rst_pmem_write", pmem_write,   0);
        chk("rst_empty",      empty,        1);
        chk("rst_mem_rdata",  mem_rdata,    0);
        chk("rst_pmem_addr",  pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata,   0);
        rst_n = 1'b1;
        tick();

        // Writeback absorb and idle drain
        mem_write = 1'b1; mem_address = 16'h1230; mem_wdata = DAT_A;
        tick();
        chk("absorb_resp",   mem_resp,   1);
        chk("absorb_nowr",   pmem_write, 0);
        chk("absorb_empty",  empty,      0);
        mem_write = 1'b0;
        tick();
        chk("absorb_resp_1cyc", mem_resp, 0);
        drain("absorb_drain", 16'h1230, DAT_A);
        chk("absorb_empty_after", empty, 1);

        // Forwarding: read follows the write back-to-back, beating the idle drain
        mem_write = 1'b1; mem_address = 16'h4560; mem_wdata = DAT_B;
        tick();
        chk("fwd_wr_resp", mem_resp, 1);
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h4567;
        tick();
        chk("fwd_resp_early", mem_resp, 0);
        tick();
        chk("fwd_resp",   mem_resp,   1);
        chk("fwd_rdata",  mem_rdata,  DAT_B);
        chk("fwd_nopmem", pmem_read,  0);
        chk("fwd_nowr",   pmem_write, 0);
        mem_read = 1'b0;
        tick();
        drain("fwd_drain", 16'h4560, DAT_B);

        // Coalesce
        mem_write = 1'b1; mem_address = 16'h7800; mem_wdata = DAT_C;
        tick();
        chk("coal_c_resp", mem_resp, 1);
        mem_wdata = DAT_D;
        tick();
        tick();
        chk("coal_d_resp", mem_resp, 1);
        mem_write = 1'b0;
        tick();
        drain("coal_drain", 16'h7800, DAT_D);
        chk("coal_empty", empty, 1);
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pmem_write) flag = 1'b1;
        end
        chk("coal_single_drain", flag, 0);

        // Full stall: four lines back-to-back, then a fifth
        for (int i = 0; i < 4; i++) begin
            mem_write   = 1'b1;
            mem_address = 16'(i * 16);
            mem_wdata   = {96'h0, 32'hF000_0000 + 32'(i)};
            tick();
            chk("fill_resp", mem_resp, 1);
            if (i == 3) begin
                mem_address = 16'h0040;
                mem_wdata   = DAT_E;
            end
            tick();
        end
        n = 0;
        flag = 1'b0;
        while (!pmem_write && n < 20) begin
            if (mem_resp) flag = 1'b1;
            tick();
            n++;
        end
        chk("full_drain_req",  pmem_write,   1);
        chk("full_drain_addr", pmem_address, 16'h0000);
        chk("full_drain_data", pmem_wdata,   {96'h0, 32'hF000_0000});
        tick();
        if (mem_resp) flag = 1'b1;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        if (mem_resp) flag = 1'b1;
        chk("full_no_early_resp", flag, 0);
        tick();
        chk("full_accept_resp", mem_resp, 1);
        mem_write = 1'b0;
        tick();
        drain("full_d1", 16'h0010, {96'h0, 32'hF000_0001});
        drain("full_d2", 16'h0020, {96'h0, 32'hF000_0002});
        drain("full_d3", 16'h0030, {96'h0, 32'hF000_0003});
        drain("full_d4", 16'h0040, DAT_E);
        chk("full_empty", empty, 1);

        // Read miss takes priority over pending drains
        mem_write = 1'b1; mem_address = 16'hA000; mem_wdata = DAT_A;
        tick();
        chk("rm_w1_resp", mem_resp, 1);
        tick();
        mem_address = 16'hB000; mem_wdata = DAT_B;
        tick();
        chk("rm_w2_resp", mem_resp, 1);
        mem_write = 1'b0; mem_read = 1'b1; mem_address = 16'h9990;
        tick();
        tick();
        chk("rm_pmem_read", pmem_read,    1);
        chk("rm_no_write",  pmem_write,   0);
        chk("rm_addr",      pmem_address, 16'h9990);
        tick();
        tick();
        chk("rm_wait_read", pmem_read, 1);
        chk("rm_wait_resp", mem_resp,  0);
        pmem_rdata = DAT_R;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        chk("rm_resp",      mem_resp,  1);
        chk("rm_rdata",     mem_rdata, DAT_R);
        chk("rm_read_drop", pmem_read, 0);
        mem_read = 1'b0;
        tick();
        drain("rm_d1", 16'hA000, DAT_A);
        drain("rm_d2", 16'hB000, DAT_B);

        // Async reset during a drain
        mem_write = 1'b1; mem_address = 16'hC000; mem_wdata = DAT_G;
        tick();
        chk("ar_wr_resp", mem_resp, 1);
        mem_write = 1'b0;
        n = 0;
        while (!pmem_write && n < 20) begin
            tick();
            n++;
        end
        chk("ar_drain_start", pmem_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pmem_write", pmem_write,   0);
        chk("ar_empty",      empty,        1);
        chk("ar_pmem_addr",  pmem_address, 0);
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pmem_write || pmem_read) flag = 1'b1;
        end
        chk("ar_no_drain",   flag,  0);
        chk("ar_empty_after", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
